onehot_decoder_hold: RTL and testbench
======================================

Name: onehot_decoder_hold

Overview:
- Sequential counterpart to the team's 4-to-2 priority encoders: accepts encoded indices over a valid/ready handshake and regenerates one-hot select lines.
- Each one-hot code is held for a programmable number of cycles.
- A 2-entry FIFO absorbs bursts from the upstream encoder.
- Drives one-hot select or indicator lines, e.g. LED banks or mux selects, from an encoded source.

Parameters:
- IN_W, 2, width of the encoded index.
- OUT_W, 1<<IN_W (4), width of the one-hot output.
- HOLD, 4, cycles each decoded code is driven. Legal range is 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  IN_W  encoded index to decode.
- in_ready  output  1  block can accept a code this cycle.
- flush  input  1  synchronous clear of FIFO and output.
- out_onehot  output  OUT_W  registered one-hot output, or all zeros when idle.
- out_active  output  1  high when out_onehot != 0.
- busy  output  1  high when FIFO is non-empty or the FSM is in DRIVE.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: out_onehot=0, out_active=0, busy=0, in_ready=1. FIFO empty, FSM in IDLE, hold counter=0.
- Reset asserted mid-operation clears everything at once, with no wait for the clock. Queued codes are discarded.
- Accept: a code is pushed on a rising edge when in_valid && in_ready.
- in_ready = !fifo_full, purely from registered state.
  - When full, no push occurs even if a pop happens in the same cycle. There is no same-cycle pass-through.
- FIFO: 2 entries, first in first out. Occupancy counter is 0..2. Read and write pointers are 1 bit each and wrap 1->0.
- Simultaneous push and pop with occupancy 1 leaves occupancy at 1, and the pushed code becomes the head.
- FSM states: IDLE, DRIVE.
  - IDLE, FIFO non-empty: pop head, set out_onehot = 1 << code, load cnt = HOLD-1, go to DRIVE.
  - IDLE, FIFO empty: out_onehot stays 0.
  - DRIVE, cnt != 0: cnt decrements and out_onehot holds.
  - DRIVE, cnt == 0, FIFO non-empty: pop and load the next code directly, with no zero gap between codes. cnt reloads HOLD-1.
  - DRIVE, cnt == 0, FIFO empty: out_onehot=0, go to IDLE.
- Latency: a code pushed at edge N into an empty, idle block appears on out_onehot at edge N+1. It is held for exactly HOLD cycles.
- HOLD=1: each code is driven for exactly one cycle. Back-to-back codes change every cycle.
- Exactly one bit of out_onehot is set in DRIVE, and none in IDLE. out_active = |out_onehot, registered alongside it.
- flush: sampled on the rising edge.
  - Empties the FIFO, sets out_onehot=0, enters IDLE, clears cnt.
  - Flush takes priority over a simultaneous push. The push is dropped, though in_ready may have been 1. The upstream source must not treat that transfer as completed.
- Codes are taken as-is. Every IN_W-bit value maps to a legal one-hot output, so no error path exists.

Test Plan:
- Single code, HOLD=4: push in_code=2 at edge 0 -> out_onehot=4'b0100 on edges 1..4. out_onehot=0 and busy=0 from edge 5.
- Back-to-back: push 3 then 0 on consecutive edges -> 4'b1000 for 4 cycles, then 4'b0001 for 4 cycles with no zero cycle between, then 0.
- Backpressure: hold in_valid=1 with codes 1,2,3,0 while the first code is driving -> in_ready drops to 0 after 2 codes are queued. It returns to 1 one cycle after each pop. The output order is 0010, 0100, 1000, 0001, with no code lost or duplicated.
- Flush and reset: flush=1 at cycle 2 of a DRIVE with 1 entry queued -> out_onehot=0 next edge, FIFO empty, in_ready=1. Separately, assert rst_n=0 mid-DRIVE -> out_onehot=0 immediately, with no wait for the clock.
- HOLD=1 sweep: push codes 0..3 every cycle -> output 0001, 0010, 0100, 1000 on consecutive edges. out_active stays 1 throughout.
- Round trip: drive the team's 4-to-2 encoder with one-hot inputs 0001..1000, using its y as in_code and its valid as in_valid -> out_onehot equals the original one-hot input, delayed by 1 cycle.

Source files
------------

// File: rtl/onehot_decoder_hold.sv
// onehot_decoder_hold: accepts encoded indices over valid/ready, buffers up to
// two of them, and drives each as a one-hot code for HOLD consecutive cycles.
module onehot_decoder_hold #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 1 << IN_W,
    parameter int unsigned HOLD  = 4   // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_code,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_active,
    output logic             busy
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned OCC_W = 2;
    localparam int unsigned CNT_W = 8;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [IN_W-1:0]  mem_q [DEPTH];
    logic [OUT_W-1:0] onehot_d;
    logic             active_d;
    logic             busy_d;
    logic             ready_d;
    logic             push_c;
    logic             pop_c;

    // Next-state, FIFO bookkeeping and next registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        onehot_d = out_onehot;
        pop_c    = 1'b0;
        // A flush on the same edge drops the push even if in_ready was high.
        push_c   = in_valid && in_ready && !flush;

        if (flush) begin
            state_d  = IDLE;
            cnt_d    = '0;
            occ_d    = '0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            onehot_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (occ_q != '0) begin
                        pop_c = 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (occ_q != '0) begin
                        pop_c = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Loading straight from the FIFO head keeps codes gap-free.
            if (pop_c) begin
                state_d  = DRIVE;
                cnt_d    = CNT_LOAD;
                onehot_d = OUT_W'(1) << mem_q[rd_ptr_q];
                rd_ptr_d = ~rd_ptr_q;
            end

            if (push_c) begin
                wr_ptr_d = ~wr_ptr_q;
            end

            case ({push_c, pop_c})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end

        active_d = |onehot_d;
        busy_d   = (occ_d != '0) || (state_d == DRIVE);
        ready_d  = (occ_d != OCC_FULL);
    end

    // State, counter, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            out_onehot <= '0;
            out_active <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_onehot <= onehot_d;
            out_active <= active_d;
            busy       <= busy_d;
            in_ready   <= ready_d;
        end
    end

    // FIFO storage; written only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= in_code;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_hold.sv
// Bench for onehot_decoder_hold: HOLD=4 and HOLD=1 instances, each with a
// scoreboard queue of expected one-hot codes plus directed timing checks.
module tb_onehot_decoder_hold;

    localparam int H4 = 4;
    localparam int H1 = 1;

    logic clk;
    logic rst_n;

    logic       v4, f4, rdy4, act4, busy4;
    logic [1:0] c4;
    logic [3:0] o4;
    logic       v1, f1, rdy1, act1, busy1;
    logic [1:0] c1;
    logic [3:0] o1;

    int n_chk;
    int n_pass;

    logic [3:0] sb4[$];
    logic [3:0] sb1[$];
    int         run4, run1;
    logic [3:0] cur4, cur1;

    logic [3:0] bb_exp [9] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
                               4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    logic       bp_rdy [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] bp_code [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] rt_pat [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                                4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};

    onehot_decoder_hold #(.IN_W(2), .OUT_W(4), .HOLD(H4)) u_h4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v4),
        .in_code    (c4),
        .in_ready   (rdy4),
        .flush      (f4),
        .out_onehot (o4),
        .out_active (act4),
        .busy       (busy4)
    );

    onehot_decoder_hold #(.IN_W(2), .OUT_W(4), .HOLD(H1)) u_h1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v1),
        .in_code    (c1),
        .in_ready   (rdy1),
        .flush      (f1),
        .out_onehot (o1),
        .out_active (act1),
        .busy       (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] enc(input logic [3:0] x);
        enc = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (x[i]) enc = 2'(i);
        end
    endfunction

    task automatic drain4();
        for (int i = 0; i < 40 && busy4; i++) step();
        chk("drain4", busy4, 0);
    endtask

    // HOLD=4 scoreboard: checks the previous edge's output, then records the
    // code (or flush) about to be taken on the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb4.delete();
            run4 = 0;
        end else begin
            if (o4 != 4'b0) begin
                if (run4 == 0 || run4 == H4) begin
                    if (sb4.size() == 0) begin
                        chk("sb4_extra", o4, 0);
                    end else begin
                        cur4 = sb4.pop_front();
                        chk("sb4_code", o4, cur4);
                    end
                    run4 = 1;
                end else begin
                    chk("sb4_hold", o4, cur4);
                    run4++;
                end
                chk("sb4_act", act4, 1);
            end else begin
                if (run4 != 0) chk("sb4_len", run4, H4);
                chk("sb4_act", act4, 0);
                run4 = 0;
            end
            if (f4) begin
                sb4.delete();
                run4 = 0;
            end else if (v4 && rdy4) begin
                sb4.push_back(4'(1) << c4);
            end
        end
    end

    // HOLD=1 scoreboard, same scheme.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb1.delete();
            run1 = 0;
        end else begin
            if (o1 != 4'b0) begin
                if (run1 == 0 || run1 == H1) begin
                    if (sb1.size() == 0) begin
                        chk("sb1_extra", o1, 0);
                    end else begin
                        cur1 = sb1.pop_front();
                        chk("sb1_code", o1, cur1);
                    end
                    run1 = 1;
                end else begin
                    chk("sb1_hold", o1, cur1);
                    run1++;
                end
                chk("sb1_act", act1, 1);
            end else begin
                if (run1 != 0) chk("sb1_len", run1, H1);
                chk("sb1_act", act1, 0);
                run1 = 0;
            end
            if (f1) begin
                sb1.delete();
                run1 = 0;
            end else if (v1 && rdy1) begin
                sb1.push_back(4'(1) << c1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic rdy_pre;
        n_chk  = 0;
        n_pass = 0;
        run4 = 0; run1 = 0;
        cur4 = '0; cur1 = '0;
        rst_n = 1'b0;
        v4 = 1'b0; c4 = '0; f4 = 1'b0;
        v1 = 1'b0; c1 = '0; f1 = 1'b0;

        // Reset values, with a clock edge seen while reset is held.
        #8;
        chk("rst_out4", o4, 0);
        chk("rst_act4", act4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_rdy4", rdy4, 1);
        chk("rst_out1", o1, 0);
        chk("rst_rdy1", rdy1, 1);
        #4 rst_n = 1'b1;
        step();

        // Single code: edge 0 push, driven on edges 1..4, idle from edge 5.
        v4 = 1'b1; c4 = 2'd2;
        step();
        v4 = 1'b0;
        chk("single_lat0", o4, 0);
        chk("single_busy", busy4, 1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("single_hold", o4, 4'b0100);
        end
        step();
        chk("single_end", o4, 0);
        chk("single_idle", busy4, 0);
        step();

        // Back-to-back codes with no zero gap.
        v4 = 1'b1; c4 = 2'd3;
        step();
        c4 = 2'd0;
        step();
        v4 = 1'b0;
        chk("b2b_0", o4, bb_exp[0]);
        for (int k = 1; k < 9; k++) begin
            step();
            chk("b2b", o4, bb_exp[k]);
        end
        drain4();

        // Backpressure: valid held high, code advances only on acceptance.
        idx = 0;
        v4 = 1'b1; c4 = bp_code[0];
        for (int cyc = 0; cyc < 12; cyc++) begin
            rdy_pre = rdy4;
            step();
            chk("bp_ready", rdy4, bp_rdy[cyc]);
            if (rdy_pre && v4) begin
                idx++;
                if (idx == 4) v4 = 1'b0;
                else c4 = bp_code[idx];
            end
        end
        chk("bp_all_sent", idx, 4);
        drain4();
        chk("bp_sb_empty", sb4.size(), 0);

        // Flush during DRIVE with one entry queued, plus a dropped push.
        v4 = 1'b1; c4 = 2'd1;
        step();
        c4 = 2'd2;
        step();
        v4 = 1'b0;
        step();
        chk("fl_pre", o4, 4'b0010);
        f4 = 1'b1; v4 = 1'b1; c4 = 2'd3;
        step();
        f4 = 1'b0; v4 = 1'b0;
        chk("fl_out", o4, 0);
        chk("fl_act", act4, 0);
        chk("fl_busy", busy4, 0);
        chk("fl_rdy", rdy4, 1);
        for (int k = 0; k < 6; k++) step();
        chk("fl_stay", o4, 0);
        chk("fl_stay_busy", busy4, 0);

        // Asynchronous reset mid-DRIVE.
        v4 = 1'b1; c4 = 2'd3;
        step();
        v4 = 1'b0;
        step();
        chk("ar_pre", o4, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out", o4, 0);
        chk("ar_act", act4, 0);
        chk("ar_busy", busy4, 0);
        chk("ar_rdy", rdy4, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        step();
        chk("ar_after", o4, 0);

        // HOLD=1 sweep: codes 0..3 pushed every cycle.
        v1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c1 = 2'(i);
            step();
            chk("h1_rdy", rdy1, 1);
            if (i > 0) begin
                chk("h1_sweep", o1, 4'(1) << (i - 1));
                chk("h1_act", act1, 1);
            end
        end
        v1 = 1'b0;
        step();
        chk("h1_last", o1, 4'b1000);
        chk("h1_last_act", act1, 1);
        step();
        chk("h1_end", o1, 0);
        step();

        // Round trip through a 4-to-2 priority encoder model.
        for (int i = 0; i < 10; i++) begin
            v1 = |rt_pat[i];
            c1 = enc(rt_pat[i]);
            step();
            if (i > 0) chk("rt", o1, rt_pat[i-1]);
        end
        v1 = 1'b0;
        step();
        chk("rt_tail", o1, rt_pat[9]);
        step();
        chk("rt_idle", busy1, 0);
        chk("h1_sb_empty", sb1.size(), 0);
        chk("h4_sb_empty", sb4.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
